// File: rtl/icache_pkg.sv
// Shared types for the direct-mapped instruction cache.
// Widths here describe the default 16-frame configuration.
package icache_pkg;

   localparam int unsigned IIDX_W = 4;
   localparam int unsigned ITAG_W = 32 - IIDX_W - 2;

   typedef struct packed {
      logic [ITAG_W-1:0] tag;
      logic [IIDX_W-1:0] idx;
      logic [1:0]        bytoff;
   } icachef_t;

   typedef struct packed {
      logic              valid;
      logic [ITAG_W-1:0] tag;
      logic [31:0]       data;
   } icache_frame_t;

   typedef enum logic {IDLE, MISS} icache_state_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with single-word refills.
// Define ICACHE_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module icache
   import icache_pkg::*;
#(
   parameter int unsigned SETS   = 16,
   parameter int unsigned WORD_W = 32
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              imemREN,
   input  logic [WORD_W-1:0] imemaddr,
   output logic              ihit,
   output logic [WORD_W-1:0] imemload,
   output logic              iREN,
   output logic [WORD_W-1:0] iaddr,
   input  logic              iwait,
   input  logic [WORD_W-1:0] iload
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0]       hit_cnt,
   output logic [31:0]       miss_cnt
`endif
);

   localparam int unsigned IDXW = $clog2(SETS);
   localparam int unsigned TAGW = WORD_W - IDXW - 2;

   logic [SETS-1:0]   valid_q;
   logic [TAGW-1:0]   tag_q  [SETS];
   logic [WORD_W-1:0] data_q [SETS];

   icache_state_t     state_q;
   logic [WORD_W-1:0] missaddr_q;

   logic [IDXW-1:0]   idx, miss_idx;
   logic [TAGW-1:0]   tag, miss_tag;
   logic              hit, fill, start_miss;
   logic              unused_boff;

   assign idx      = imemaddr[IDXW+1:2];
   assign tag      = imemaddr[WORD_W-1:IDXW+2];
   assign miss_idx = missaddr_q[IDXW+1:2];
   assign miss_tag = missaddr_q[WORD_W-1:IDXW+2];
   assign unused_boff = ^imemaddr[1:0];

   assign hit        = (state_q == IDLE) & imemREN & valid_q[idx] & (tag_q[idx] == tag);
   assign start_miss = (state_q == IDLE) & imemREN & ~hit;
   assign fill       = (state_q == MISS) & ~iwait;

   assign ihit     = hit;
   assign imemload = hit ? data_q[idx] : '0;
   assign iREN     = (state_q == MISS);
   // Low address bits are zeroed at latch time, so the register is the word address.
   assign iaddr    = (state_q == MISS) ? missaddr_q : '0;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q    <= IDLE;
         missaddr_q <= '0;
         valid_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_miss) begin
                  missaddr_q <= {imemaddr[WORD_W-1:2], 2'b00};
                  state_q    <= MISS;
               end
            end
            MISS: begin
               if (!iwait) begin
                  valid_q[miss_idx] <= 1'b1;
                  state_q           <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Tag/data need no reset: valid_q alone qualifies them.
   always_ff @(posedge CLK) begin
      if (fill) begin
         tag_q[miss_idx]  <= miss_tag;
         data_q[miss_idx] <= iload;
      end
   end

`ifdef ICACHE_STATS_EN
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         if (hit && hit_cnt != 32'hFFFF_FFFF) begin
            hit_cnt <= hit_cnt + 32'd1;
         end
         if (start_miss && miss_cnt != 32'hFFFF_FFFF) begin
            miss_cnt <= miss_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_icache.sv
// Directed, table-driven bench for icache; one table row per clock cycle.
module tb_icache;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;
`endif

   int passed = 0;
   int total  = 0;

   icache dut (
      .CLK      (CLK),
      .nRST     (nRST),
      .imemREN  (imemREN),
      .imemaddr (imemaddr),
      .ihit     (ihit),
      .imemload (imemload),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .iwait    (iwait),
      .iload    (iload)
`ifdef ICACHE_STATS_EN
      ,
      .hit_cnt  (hit_cnt),
      .miss_cnt (miss_cnt)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        ren;
      logic [31:0] addr;
      logic        iw;
      logic [31:0] ld;
      logic        e_hit;
      logic [31:0] e_load;
      logic        e_ren;
      logic [31:0] e_iaddr;
   } vec_t;

   localparam int NV = 26;
   vec_t vec [NV];

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
   endtask

   task automatic drive(input logic ren, input logic [31:0] addr, input logic iw,
                        input logic [31:0] ld);
      imemREN  = ren;
      imemaddr = addr;
      iwait    = iw;
      iload    = ld;
   endtask

   initial begin
      // Cold miss on 0x40 with three wait cycles, then hits.
      vec[0]  = '{1'b1, 32'h40,  1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
      vec[1]  = '{1'b1, 32'h40,  1'b1, 32'h0,         1'b0, 32'h0,         1'b1, 32'h40};
      vec[2]  = '{1'b1, 32'h40,  1'b1, 32'h0,         1'b0, 32'h0,         1'b1, 32'h40};
      vec[3]  = '{1'b1, 32'h40,  1'b1, 32'h0,         1'b0, 32'h0,         1'b1, 32'h40};
      vec[4]  = '{1'b1, 32'h40,  1'b0, 32'h2001_0005, 1'b0, 32'h0,         1'b1, 32'h40};
      vec[5]  = '{1'b1, 32'h40,  1'b1, 32'h0,         1'b1, 32'h2001_0005, 1'b0, 32'h0};
      vec[6]  = '{1'b1, 32'h40,  1'b0, 32'h0,         1'b1, 32'h2001_0005, 1'b0, 32'h0};
      vec[7]  = '{1'b0, 32'h40,  1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
      // Conflict at index 0: 0x440 evicts 0x40.
      vec[8]  = '{1'b1, 32'h440, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
      vec[9]  = '{1'b1, 32'h440, 1'b0, 32'hAAAA_0001, 1'b0, 32'h0,         1'b1, 32'h440};
      vec[10] = '{1'b1, 32'h440, 1'b1, 32'h0,         1'b1, 32'hAAAA_0001, 1'b0, 32'h0};
      vec[11] = '{1'b1, 32'h40,  1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
      vec[12] = '{1'b1, 32'h40,  1'b0, 32'h2001_0005, 1'b0, 32'h0,         1'b1, 32'h40};
      vec[13] = '{1'b1, 32'h40,  1'b1, 32'h0,         1'b1, 32'h2001_0005, 1'b0, 32'h0};
      // Redirect and imemREN drop mid-miss: the 0x100 refill still lands.
      vec[14] = '{1'b1, 32'h100, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
      vec[15] = '{1'b1, 32'h200, 1'b1, 32'h0,         1'b0, 32'h0,         1'b1, 32'h100};
      vec[16] = '{1'b0, 32'h200, 1'b1, 32'h0,         1'b0, 32'h0,         1'b1, 32'h100};
      vec[17] = '{1'b1, 32'h200, 1'b0, 32'h1111_0100, 1'b0, 32'h0,         1'b1, 32'h100};
      vec[18] = '{1'b1, 32'h100, 1'b1, 32'h0,         1'b1, 32'h1111_0100, 1'b0, 32'h0};
      vec[19] = '{1'b1, 32'h200, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
      vec[20] = '{1'b1, 32'h200, 1'b0, 32'h2222_0200, 1'b0, 32'h0,         1'b1, 32'h200};
      vec[21] = '{1'b1, 32'h200, 1'b1, 32'h0,         1'b1, 32'h2222_0200, 1'b0, 32'h0};
      // Top index, byte offset ignored, other index untouched.
      vec[22] = '{1'b1, 32'h7C,  1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
      vec[23] = '{1'b1, 32'h7C,  1'b0, 32'h7C7C_7C7C, 1'b0, 32'h0,         1'b1, 32'h7C};
      vec[24] = '{1'b1, 32'h7E,  1'b1, 32'h0,         1'b1, 32'h7C7C_7C7C, 1'b0, 32'h0};
      vec[25] = '{1'b1, 32'h200, 1'b1, 32'h0,         1'b1, 32'h2222_0200, 1'b0, 32'h0};

      nRST = 1'b0;
      drive(1'b0, 32'h0, 1'b1, 32'h0);
      #12;
      chk("rst_ihit", 0, {31'b0, ihit}, 32'h0);
      chk("rst_iren", 0, {31'b0, iREN}, 32'h0);
      chk("rst_iaddr", 0, iaddr, 32'h0);
      chk("rst_imemload", 0, imemload, 32'h0);
`ifdef ICACHE_STATS_EN
      chk("rst_hit_cnt", 0, hit_cnt, 32'h0);
      chk("rst_miss_cnt", 0, miss_cnt, 32'h0);
`endif
      @(posedge CLK); #1;
      nRST = 1'b1;

      for (int i = 0; i < NV; i++) begin
         drive(vec[i].ren, vec[i].addr, vec[i].iw, vec[i].ld);
         @(negedge CLK);
         chk("ihit", i, {31'b0, ihit}, {31'b0, vec[i].e_hit});
         chk("imemload", i, imemload, vec[i].e_load);
         chk("iREN", i, {31'b0, iREN}, {31'b0, vec[i].e_ren});
         chk("iaddr", i, iaddr, vec[i].e_iaddr);
         @(posedge CLK); #1;
      end
`ifdef ICACHE_STATS_EN
      chk("tbl_hit_cnt", 0, hit_cnt, 32'd8);
      chk("tbl_miss_cnt", 0, miss_cnt, 32'd6);
`endif

      // Reset during MISS: iREN drops at once and nothing is filled.
      drive(1'b1, 32'h300, 1'b1, 32'h0);
      @(negedge CLK);
      chk("pre_miss_ihit", 0, {31'b0, ihit}, 32'h0);
      @(posedge CLK); #1;
      drive(1'b1, 32'h300, 1'b1, 32'h0);
      @(negedge CLK);
      chk("mid_miss_iren", 0, {31'b0, iREN}, 32'h1);
      chk("mid_miss_iaddr", 0, iaddr, 32'h300);
      #1;
      iwait = 1'b0;
      iload = 32'hDEAD_BEEF;
      nRST  = 1'b0;
      #1;
      chk("async_iren", 0, {31'b0, iREN}, 32'h0);
      chk("async_iaddr", 0, iaddr, 32'h0);
      @(posedge CLK); #1;
      nRST = 1'b1;
      drive(1'b1, 32'h300, 1'b1, 32'h0);
      @(negedge CLK);
      chk("post_rst_ihit", 0, {31'b0, ihit}, 32'h0);
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("post_rst_iren", 0, {31'b0, iREN}, 32'h1);
      chk("post_rst_iaddr", 0, iaddr, 32'h300);
      iwait = 1'b0;
      iload = 32'h3000_0300;
      @(posedge CLK); #1;
      iwait = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         chk("refill_ihit", k, {31'b0, ihit}, 32'h1);
         chk("refill_load", k, imemload, 32'h3000_0300);
         chk("refill_iren", k, {31'b0, iREN}, 32'h0);
         @(posedge CLK); #1;
      end
      // Earlier frames were invalidated by the reset.
      drive(1'b1, 32'h40, 1'b1, 32'h0);
      @(negedge CLK);
`ifdef ICACHE_STATS_EN
      chk("stats_hit_cnt", 0, hit_cnt, 32'd3);
      chk("stats_miss_cnt", 0, miss_cnt, 32'd1);
`endif
      chk("inval_ihit", 0, {31'b0, ihit}, 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
